// File: rtl/contador_pkg.sv
// Shared types and helpers for the multi-mode counter: run modes, control
// states and a range clamp used when loading.
package contador_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_STOP   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    RUN_UP   = 2'd0,
    RUN_DOWN = 2'd1,
    HALTED   = 2'd2
  } state_t;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/contador_paso.sv
// Combinational step logic: next count, terminal detect and next direction
// for one enabled edge in the given mode. Arithmetic runs in N+1 bits.
module contador_paso
  import contador_pkg::*;
#(
  parameter int N   = 4,
  parameter int MIN = 0,
  parameter int MAX = (2**N) - 1
) (
  input  logic [N-1:0] q,
  input  logic         dir,
  input  mode_t        mode,
  output logic [N-1:0] q_next,
  output logic         hit_terminal,
  output logic         dir_next
);

  localparam logic [N:0] MIN_X = (N+1)'(MIN);
  localparam logic [N:0] MAX_X = (N+1)'(MAX);
  localparam logic [N:0] ONE_X = (N+1)'(1);

  logic [N:0] q_x;
  logic [N:0] inc;
  logic [N:0] dec;
  logic [N:0] term;
  logic [N:0] nxt;
  logic       at_max;
  logic       at_min;

  assign q_x    = {1'b0, q};
  assign inc    = q_x + ONE_X;
  assign dec    = q_x - ONE_X;
  assign term   = dir ? MAX_X : MIN_X;
  assign at_max = (q_x == MAX_X);
  assign at_min = (q_x == MIN_X);

  always_comb begin
    nxt          = q_x;
    dir_next     = dir;
    hit_terminal = 1'b0;
    case (mode)
      MODE_WRAP: begin
        if (dir) nxt = at_max ? MIN_X : inc;
        else     nxt = at_min ? MAX_X : dec;
        hit_terminal = (nxt == term);
      end
      MODE_STOP: begin
        // Sitting on the terminal value still reports the hit so a load
        // straight onto it halts on the next enabled edge.
        if ((dir && at_max) || (!dir && at_min)) begin
          nxt          = q_x;
          hit_terminal = 1'b1;
        end else begin
          nxt          = dir ? inc : dec;
          hit_terminal = (nxt == term);
        end
      end
      MODE_BOUNCE: begin
        if (dir && at_max) begin
          nxt      = MAX_X - ONE_X;
          dir_next = 1'b0;
        end else if (!dir && at_min) begin
          nxt      = MIN_X + ONE_X;
          dir_next = 1'b1;
        end else begin
          nxt = dir ? inc : dec;
        end
        hit_terminal = (nxt == MAX_X) || (nxt == MIN_X);
      end
      default: begin
        nxt          = q_x;
        hit_terminal = 1'b0;
      end
    endcase
    q_next = nxt[N-1:0];
  end

endmodule

// File: rtl/contador_modo.sv
// Multi-mode N-bit counter over [MIN, MAX] with wrap/stop/bounce/hold modes,
// synchronous clear/load, one-cycle terminal pulse and sticky done flag.
module contador_modo
  import contador_pkg::*;
#(
  parameter int N   = 4,
  parameter int MIN = 0,
  parameter int MAX = (2**N) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         up,
  input  logic [1:0]   mode,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         done,
  output logic         dir_o,
  output state_t       state
);

  if (!(MIN < MAX && MAX <= (2**N) - 1)) begin : g_bad_range
    $error("contador_modo: range must satisfy MIN < MAX <= 2**N-1");
  end

  // Control handshake: clear, load and en are level inputs sampled on each
  // rising edge with priority clear > load > en; there is no back-pressure.
  mode_t        mode_cur;
  logic         dir_eff;
  logic [N-1:0] q_next;
  logic         hit_terminal;
  logic         dir_next;

  assign mode_cur = mode_t'(mode);
  assign dir_eff  = (mode_cur == MODE_BOUNCE) ? (state != RUN_DOWN) : up;

  contador_paso #(
    .N   (N),
    .MIN (MIN),
    .MAX (MAX)
  ) u_paso (
    .q            (q),
    .dir          (dir_eff),
    .mode         (mode_cur),
    .q_next       (q_next),
    .hit_terminal (hit_terminal),
    .dir_next     (dir_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= N'(MIN);
      tc    <= 1'b0;
      done  <= 1'b0;
      dir_o <= 1'b1;
      state <= RUN_UP;
    end else if (clear) begin
      q     <= N'(MIN);
      tc    <= 1'b0;
      done  <= 1'b0;
      dir_o <= 1'b1;
      state <= RUN_UP;
    end else if (load) begin
      q     <= N'(clamp(int'(d), MIN, MAX));
      tc    <= 1'b0;
      done  <= 1'b0;
      dir_o <= up;
      state <= up ? RUN_UP : RUN_DOWN;
    end else if (!en || mode_cur == MODE_HOLD || state == HALTED) begin
      tc <= 1'b0;
    end else begin
      q     <= q_next;
      tc    <= hit_terminal;
      dir_o <= dir_next;
      if (mode_cur == MODE_STOP && hit_terminal) begin
        done  <= 1'b1;
        state <= HALTED;
      end else begin
        state <= dir_next ? RUN_UP : RUN_DOWN;
      end
    end
  end

endmodule

// File: tb/tb_contador_modo.sv
// Scoreboard bench for contador_modo with N=4, MIN=0, MAX=9: expected
// {q, tc, done, dir_o} words are queued per edge and popped after it.
module tb_contador_modo;
  import contador_pkg::*;

  localparam int W = 7;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clear;
  logic       load;
  logic [3:0] d;
  logic       up;
  logic [1:0] mode;
  logic [3:0] q;
  logic       tc;
  logic       done;
  logic       dir_o;
  state_t     state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  logic [W-1:0] obs_w;
  int checks;
  int errors;

  contador_modo #(.N(4), .MIN(0), .MAX(9)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (clear),
    .load  (load),
    .d     (d),
    .up    (up),
    .mode  (mode),
    .q     (q),
    .tc    (tc),
    .done  (done),
    .dir_o (dir_o),
    .state (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input int qv, input bit tcv, input bit dv, input bit dirv);
    logic [3:0] q4;
    q4 = qv[3:0];
    return {q4, tcv, dv, dirv};
  endfunction

  // driver: apply inputs, take one rising edge, settle 1 time unit past it
  task automatic drive(input bit e, input bit c, input bit l, input int dv, input bit u, input mode_t m);
    en    = e;
    clear = c;
    load  = l;
    d     = dv[3:0];
    up    = u;
    mode  = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 0, 0, 0, 1, MODE_WRAP);
    drive(1, 0, 0, 0, 1, MODE_WRAP);
    exp_q.push_back(pack(0, 0, 0, 1));
    exp_w = exp_q.pop_front();
    obs_w = {q, tc, done, dir_o};
    checks++;
    if (obs_w !== exp_w) begin
      errors++;
      $display("FAIL reset_initial got %h expected %h", obs_w, exp_w);
    end
    rst = 1'b1;
    drive(0, 0, 1, 5, 1, MODE_WRAP);
    exp_q.push_back(pack(5, 0, 0, 1));
    exp_w = exp_q.pop_front();
    obs_w = {q, tc, done, dir_o};
    checks++;
    if (obs_w !== exp_w) begin
      errors++;
      $display("FAIL reset_preload got %h expected %h", obs_w, exp_w);
    end
    // asynchronous drop mid-cycle, observed before any edge
    #2;
    rst = 1'b0;
    #1;
    exp_q.push_back(pack(0, 0, 0, 1));
    exp_w = exp_q.pop_front();
    obs_w = {q, tc, done, dir_o};
    checks++;
    if (obs_w !== exp_w) begin
      errors++;
      $display("FAIL reset_async got %h expected %h", obs_w, exp_w);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pack(0, 0, 0, 1));
      drive(1, 0, 0, 0, 1, MODE_WRAP);
      exp_w = exp_q.pop_front();
      obs_w = {q, tc, done, dir_o};
      checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL reset_held[%0d] got %h expected %h", i, obs_w, exp_w);
      end
    end
    rst = 1'b1;
    exp_q.push_back(pack(1, 0, 0, 1));
    drive(1, 0, 0, 0, 1, MODE_WRAP);
    exp_w = exp_q.pop_front();
    obs_w = {q, tc, done, dir_o};
    checks++;
    if (obs_w !== exp_w) begin
      errors++;
      $display("FAIL reset_first_step got %h expected %h", obs_w, exp_w);
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 0, 1, MODE_WRAP);
    for (int i = 1; i <= 12; i++) begin
      exp_q.push_back(pack(i % 10, (i % 10) == 9, 0, 1));
      drive(1, 0, 0, 0, 1, MODE_WRAP);
      exp_w = exp_q.pop_front();
      obs_w = {q, tc, done, dir_o};
      checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL wrap_up[%0d] got %h expected %h", i, obs_w, exp_w);
      end
    end
    exp_q.push_back(pack(1, 0, 0, 0));
    drive(0, 0, 1, 1, 0, MODE_WRAP);
    exp_q.push_back(pack(0, 1, 0, 0));
    drive(1, 0, 0, 0, 0, MODE_WRAP);
    exp_w = exp_q.pop_front();
    checks++;
    if (exp_w[6:3] !== 4'd1) begin
      errors++;
      $display("FAIL wrap_scoreboard_order got %h expected q=1", exp_w);
    end
    exp_w = exp_q.pop_front();
    obs_w = {q, tc, done, dir_o};
    checks++;
    if (obs_w !== exp_w) begin
      errors++;
      $display("FAIL wrap_down_min got %h expected %h", obs_w, exp_w);
    end
    exp_q.push_back(pack(9, 0, 0, 0));
    drive(1, 0, 0, 0, 0, MODE_WRAP);
    exp_w = exp_q.pop_front();
    obs_w = {q, tc, done, dir_o};
    checks++;
    if (obs_w !== exp_w) begin
      errors++;
      $display("FAIL wrap_down_under got %h expected %h", obs_w, exp_w);
    end
  endtask

  task automatic test_stop();
    drive(0, 1, 0, 0, 1, MODE_STOP);
    for (int i = 1; i <= 29; i++) begin
      exp_q.push_back(pack(i > 9 ? 9 : i, i == 9, i >= 9, 1));
      drive(1, 0, 0, 0, 1, MODE_STOP);
      exp_w = exp_q.pop_front();
      obs_w = {q, tc, done, dir_o};
      checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL stop_up[%0d] got %h expected %h", i, obs_w, exp_w);
      end
    end
    checks++;
    if (state !== HALTED) begin
      errors++;
      $display("FAIL stop_state got %0d expected %0d", state, HALTED);
    end
    exp_q.push_back(pack(0, 0, 0, 1));
    drive(1, 1, 0, 0, 1, MODE_STOP);
    exp_w = exp_q.pop_front();
    obs_w = {q, tc, done, dir_o};
    checks++;
    if (obs_w !== exp_w) begin
      errors++;
      $display("FAIL stop_clear got %h expected %h", obs_w, exp_w);
    end
  endtask

  task automatic test_bounce();
    int seq[12] = '{8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int prev;
    drive(0, 0, 1, 7, 1, MODE_BOUNCE);
    prev = 7;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(pack(seq[i], seq[i] == 9 || seq[i] == 0, 0, seq[i] > prev));
      drive(1, 0, 0, 0, 0, MODE_BOUNCE);
      prev = seq[i];
      exp_w = exp_q.pop_front();
      obs_w = {q, tc, done, dir_o};
      checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL bounce[%0d] got %h expected %h", i, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_load();
    // each row: en clear load d up mode, then expected q tc done dir
    int rows[6][10] = '{
      '{0, 0, 1, 12, 1, 0,  9, 0, 0, 1},
      '{1, 0, 1,  3, 1, 0,  3, 0, 0, 1},
      '{1, 1, 1,  6, 0, 0,  0, 0, 0, 1},
      '{0, 0, 1,  9, 1, 1,  9, 0, 0, 1},
      '{1, 0, 0,  0, 1, 1,  9, 1, 1, 1},
      '{1, 0, 1,  4, 1, 1,  4, 0, 0, 1}
    };
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(pack(rows[i][6], rows[i][7] != 0, rows[i][8] != 0, rows[i][9] != 0));
      drive(rows[i][0] != 0, rows[i][1] != 0, rows[i][2] != 0, rows[i][3],
            rows[i][4] != 0, mode_t'(rows[i][5][1:0]));
      exp_w = exp_q.pop_front();
      obs_w = {q, tc, done, dir_o};
      checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL load_row[%0d] got %h expected %h", i, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(pack(4, 0, 0, 1));
      if (i < 5) drive(1, 0, 0, $urandom_range(0, 15), $urandom_range(0, 1), MODE_HOLD);
      else       drive(0, 0, 0, $urandom_range(0, 15), 1, MODE_WRAP);
      exp_w = exp_q.pop_front();
      obs_w = {q, tc, done, dir_o};
      checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL hold[%0d] got %h expected %h", i, obs_w, exp_w);
      end
    end
    for (int i = 5; i <= 6; i++) begin
      exp_q.push_back(pack(i, 0, 0, 1));
      drive(1, 0, 0, 0, 1, MODE_WRAP);
      exp_w = exp_q.pop_front();
      obs_w = {q, tc, done, dir_o};
      checks++;
      if (obs_w !== exp_w) begin
        errors++;
        $display("FAIL hold_resume[%0d] got %h expected %h", i, obs_w, exp_w);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    en     = 1'b0;
    clear  = 1'b0;
    load   = 1'b0;
    d      = 4'd0;
    up     = 1'b1;
    mode   = 2'd0;
    test_reset();
    test_wrap();
    test_stop();
    test_bounce();
    test_load();
    test_hold();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
